// File: rtl/add8u_err_pkg.sv
// Shared types, widths and the saturating-add helper for the approximate-adder
// error monitor.
package add8u_err_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    REPORT
  } state_t;

  localparam int OP_W  = 8;
  localparam int RES_W = OP_W + 1;
  localparam int SQ_W  = 2 * OP_W + 2;
  localparam int SAT_W = 64;

  // Clamps to the all-ones value of a 'width'-bit accumulator instead of wrapping.
  function automatic logic [SAT_W-1:0] sat_add(input logic [SAT_W-1:0] acc,
                                               input logic [SAT_W-1:0] inc,
                                               input int unsigned      width);
    logic [SAT_W:0] sum;
    logic [SAT_W:0] lim;
    sum = {1'b0, acc} + {1'b0, inc};
    lim = ((SAT_W + 1)'(1) << width) - (SAT_W + 1)'(1);
    if (sum > lim) sum = lim;
    return sum[SAT_W-1:0];
  endfunction

endpackage

// File: rtl/add8u_err_stage.sv
// Combinational stage-1 datapath: exact sum, absolute error and squared error
// of one sample. The parent registers the outputs.
module add8u_err_stage
  import add8u_err_pkg::*;
#(
  parameter int WIDTH = OP_W,
  parameter int RW    = RES_W,
  parameter int SW    = SQ_W
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [RW-1:0]    o,
  output logic [RW-1:0]    err,
  output logic [SW-1:0]    sq
);

  logic [RW-1:0] exact;
  logic [SW-1:0] err_w;

  always_comb begin
    exact = RW'(a) + RW'(b);
    err   = (exact >= o) ? exact - o : o - exact;
    err_w = SW'(err);
    sq    = err_w * err_w;
  end

endmodule

// File: rtl/add8u_err_monitor.sv
// Windowed error statistics for an approximate unsigned adder: accepts N samples,
// accumulates |err|, err^2, max and count, then offers one report record.
module add8u_err_monitor
  import add8u_err_pkg::*;
#(
  parameter int WIDTH = OP_W,
  parameter int CNT_W = 32,
  parameter int ACC_W = 48
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] cfg_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH:0]   in_o,
  output logic             busy,
  output logic             rpt_valid,
  input  logic             rpt_ready,
  output logic [ACC_W-1:0] rpt_sum_abs,
  output logic [ACC_W-1:0] rpt_sum_sq,
  output logic [WIDTH:0]   rpt_max,
  output logic [CNT_W-1:0] rpt_err_cnt,
  output logic [CNT_W-1:0] rpt_n
);

  localparam int RW = WIDTH + 1;
  localparam int SW = 2 * WIDTH + 2;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] n_q, cnt_q, err_cnt_q;
  logic             drain_q, accept, start_ok;
  logic [RW-1:0]    err, s1_err, max_q;
  logic [SW-1:0]    sq, s1_sq;
  logic             s1_valid;
  logic [ACC_W-1:0] sum_abs_q, sum_sq_q;

  add8u_err_stage #(.WIDTH(WIDTH), .RW(RW), .SW(SW)) u_stage (
    .a   (in_a),
    .b   (in_b),
    .o   (in_o),
    .err (err),
    .sq  (sq)
  );

  // in_ready depends only on state and counter, never on in_valid.
  assign in_ready  = (state_q == RUN) && (cnt_q < n_q);
  assign accept    = in_valid && in_ready;
  assign start_ok  = (state_q == IDLE) && start;
  assign busy      = (state_q != IDLE);
  assign rpt_valid = (state_q == REPORT);

  assign rpt_sum_abs = sum_abs_q;
  assign rpt_sum_sq  = sum_sq_q;
  assign rpt_max     = max_q;
  assign rpt_err_cnt = err_cnt_q;
  assign rpt_n       = n_q;

  // NOTE: next state gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   if (start) state_d = (cfg_n == '0) ? REPORT : RUN;
      RUN:    if (accept && (cnt_q + CNT_W'(1) == n_q)) state_d = DRAIN;
      DRAIN:  if (drain_q) state_d = REPORT;
      REPORT: if (rpt_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: all state uses non-blocking assignment so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      n_q       <= '0;
      cnt_q     <= '0;
      drain_q   <= 1'b0;
      s1_valid  <= 1'b0;
      sum_abs_q <= '0;
      sum_sq_q  <= '0;
      max_q     <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      drain_q  <= (state_q == DRAIN) && !drain_q;
      s1_valid <= accept;
      if (start_ok) begin
        n_q       <= cfg_n;
        cnt_q     <= '0;
        sum_abs_q <= '0;
        sum_sq_q  <= '0;
        max_q     <= '0;
        err_cnt_q <= '0;
      end else begin
        if (accept) cnt_q <= cnt_q + CNT_W'(1);
        if (s1_valid) begin
          sum_abs_q <= ACC_W'(sat_add(SAT_W'(sum_abs_q), SAT_W'(s1_err), ACC_W));
          sum_sq_q  <= ACC_W'(sat_add(SAT_W'(sum_sq_q), SAT_W'(s1_sq), ACC_W));
          if (s1_err > max_q) max_q <= s1_err;
          if (s1_err != '0) err_cnt_q <= err_cnt_q + CNT_W'(1);
        end
      end
    end
  end

  // NOTE: pipeline data needs no reset; s1_valid alone qualifies it.
  always_ff @(posedge clk) begin
    if (accept) begin
      s1_err <= err;
      s1_sq  <= sq;
    end
  end

endmodule

// File: tb/tb_add8u_err_monitor.sv
// Scoreboard bench: driver pushes per-window expected records computed from plain
// arithmetic; a monitor pops and compares on each report handshake.
module tb_add8u_err_monitor;

  localparam longint unsigned SAT_LIM = 1023;

  logic        clk = 1'b0;
  logic        rst, start, in_valid, rpt_ready;
  logic [31:0] cfg_n;
  logic [7:0]  in_a, in_b;
  logic [8:0]  in_o;

  logic        in_ready, busy, rpt_valid;
  logic [47:0] rpt_sum_abs, rpt_sum_sq;
  logic [8:0]  rpt_max;
  logic [31:0] rpt_err_cnt, rpt_n;

  logic        s_in_ready, s_busy, s_rpt_valid;
  logic [9:0]  s_rpt_sum_abs, s_rpt_sum_sq;
  logic [8:0]  s_rpt_max;
  logic [31:0] s_rpt_err_cnt, s_rpt_n;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    longint unsigned sum_abs;
    longint unsigned sum_sq;
    longint unsigned sat_abs;
    longint unsigned sat_sq;
    int unsigned     max;
    int unsigned     cnt;
    int unsigned     n;
  } rec_t;

  rec_t        exp_q[$];
  int unsigned errs[$];
  int unsigned cur_n;

  always #5 clk = ~clk;

  add8u_err_monitor dut (
    .clk(clk), .rst(rst), .start(start), .cfg_n(cfg_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_o(in_o),
    .busy(busy), .rpt_valid(rpt_valid), .rpt_ready(rpt_ready),
    .rpt_sum_abs(rpt_sum_abs), .rpt_sum_sq(rpt_sum_sq), .rpt_max(rpt_max),
    .rpt_err_cnt(rpt_err_cnt), .rpt_n(rpt_n)
  );

  add8u_err_monitor #(.ACC_W(10)) dut_sat (
    .clk(clk), .rst(rst), .start(start), .cfg_n(cfg_n),
    .in_valid(in_valid), .in_ready(s_in_ready),
    .in_a(in_a), .in_b(in_b), .in_o(in_o),
    .busy(s_busy), .rpt_valid(s_rpt_valid), .rpt_ready(rpt_ready),
    .rpt_sum_abs(s_rpt_sum_abs), .rpt_sum_sq(s_rpt_sum_sq), .rpt_max(s_rpt_max),
    .rpt_err_cnt(s_rpt_err_cnt), .rpt_n(s_rpt_n)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_window();
    rec_t r;
    r = '{default: 0};
    foreach (errs[i]) begin
      r.sum_abs += longint'(errs[i]);
      r.sum_sq  += longint'(errs[i]) * longint'(errs[i]);
      if (errs[i] > r.max) r.max = errs[i];
      if (errs[i] != 0) r.cnt++;
    end
    r.n       = cur_n;
    r.sat_abs = (r.sum_abs > SAT_LIM) ? SAT_LIM : r.sum_abs;
    r.sat_sq  = (r.sum_sq > SAT_LIM) ? SAT_LIM : r.sum_sq;
    exp_q.push_back(r);
    errs.delete();
  endtask

  task automatic start_win(input int unsigned n);
    start = 1'b1;
    cfg_n = n;
    tick();
    start = 1'b0;
    cur_n = n;
    errs.delete();
    if (n == 0) push_window();
  endtask

  task automatic send(input int unsigned a, input int unsigned b, input int unsigned o,
                      input int unsigned gap);
    logic acc;
    int   d;
    acc = 1'b0;
    repeat (gap) tick();
    in_valid = 1'b1;
    in_a = 8'(a);
    in_b = 8'(b);
    in_o = 9'(o);
    for (int k = 0; k < 50; k++) begin
      acc = in_ready;
      tick();
      if (acc) break;
    end
    in_valid = 1'b0;
    check("accept_timeout", 64'(acc), 64'd1);
    d = int'(a) + int'(b) - int'(o);
    errs.push_back(d < 0 ? -d : d);
    if (errs.size() == cur_n) push_window();
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 100; k++) begin
      if (!busy) break;
      tick();
    end
    check("idle_timeout", 64'(busy), 64'd0);
  endtask

  always @(negedge clk) begin
    if (!rst && rpt_valid && rpt_ready) begin
      if (exp_q.size() == 0) begin
        check("rpt_unexpected", 64'(exp_q.size()), 64'd1);
      end else begin
        rec_t e;
        e = exp_q.pop_front();
        check("sum_abs", 64'(rpt_sum_abs), e.sum_abs);
        check("sum_sq", 64'(rpt_sum_sq), e.sum_sq);
        check("max", 64'(rpt_max), 64'(e.max));
        check("err_cnt", 64'(rpt_err_cnt), 64'(e.cnt));
        check("rpt_n", 64'(rpt_n), 64'(e.n));
        check("sat_valid", 64'(s_rpt_valid), 64'd1);
        check("sat_sum_abs", 64'(s_rpt_sum_abs), e.sat_abs);
        check("sat_sum_sq", 64'(s_rpt_sum_sq), e.sat_sq);
        check("sat_max", 64'(s_rpt_max), 64'(e.max));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned n, a, b, o, ex;
    rst = 1'b1; start = 1'b0; cfg_n = '0; in_valid = 1'b0;
    in_a = '0; in_b = '0; in_o = '0; rpt_ready = 1'b1;
    repeat (3) tick();
    check("rst_in_ready", 64'(in_ready), 0);
    check("rst_busy", 64'(busy), 0);
    check("rst_rpt_valid", 64'(rpt_valid), 0);
    check("rst_fields", 64'(rpt_sum_abs | rpt_sum_sq | 48'(rpt_max) | 48'(rpt_err_cnt) | 48'(rpt_n)), 0);
    rst = 1'b0;
    tick();

    // Exact adder results over a 16-sample window.
    start_win(16);
    for (int i = 0; i < 16; i++) begin
      a = $urandom_range(0, 255);
      b = $urandom_range(0, 255);
      send(a, b, a + b, 0);
    end
    wait_idle();

    // Constant error of 8; fields must hold after the handshake.
    start_win(4);
    for (int i = 0; i < 4; i++) send(0, 0, 8, 0);
    wait_idle();
    check("hold_sum_abs", 64'(rpt_sum_abs), 32);
    check("hold_rpt_valid", 64'(rpt_valid), 0);

    // Mixed errors with idle gaps.
    start_win(3);
    send(255, 255, 0, 2);
    send(1, 1, 2, 3);
    send(3, 4, 3, 1);
    check("ready_drop", 64'(in_ready), 0);
    check("busy_drain", 64'(busy), 1);
    wait_idle();

    // Zero-length window under backpressure, with an ignored second start.
    rpt_ready = 1'b0;
    start_win(0);
    check("zero_rpt_valid", 64'(rpt_valid), 1);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        start = 1'b1;
        cfg_n = 5;
      end
      tick();
      start = 1'b0;
      check("hold_valid", 64'(rpt_valid), 1);
      check("hold_n", 64'(rpt_n), 0);
      check("hold_abs", 64'(rpt_sum_abs), 0);
    end
    rpt_ready = 1'b1;
    tick();
    check("zero_done_busy", 64'(busy), 0);

    // Reset in the middle of a window.
    start_win(8);
    for (int i = 0; i < 5; i++) send(10, 20, 31, 0);
    rst = 1'b1;
    tick();
    check("midrst_busy", 64'(busy), 0);
    check("midrst_in_ready", 64'(in_ready), 0);
    check("midrst_rpt_valid", 64'(rpt_valid), 0);
    check("midrst_sum_abs", 64'(rpt_sum_abs), 0);
    rst = 1'b0;
    errs.delete();
    tick();
    start_win(1);
    send(1, 1, 1, 0);
    wait_idle();
    check("post_rst_sum_abs", 64'(rpt_sum_abs), 1);

    // Saturation of the narrow accumulators (wide one does not saturate).
    start_win(4);
    for (int i = 0; i < 4; i++) send(255, 255, 0, 0);
    wait_idle();

    // Random windows with gaps and report backpressure.
    for (int w = 0; w < 5; w++) begin
      n = $urandom_range(1, 12);
      start_win(n);
      for (int i = 0; i < int'(n); i++) begin
        a  = $urandom_range(0, 255);
        b  = $urandom_range(0, 255);
        ex = a + b;
        if ($urandom_range(0, 3) == 0) o = $urandom_range(0, 511);
        else o = (ex + $urandom_range(0, 6) >= 3) ? ex + $urandom_range(0, 6) - 3 : 0;
        if (o > 511) o = 511;
        send(a, b, o, $urandom_range(0, 2));
      end
      rpt_ready = 1'b0;
      repeat ($urandom_range(0, 4)) tick();
      rpt_ready = 1'b1;
      wait_idle();
    end

    check("scoreboard_empty", 64'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
